// File: rtl/fifo_sync_flags_pkg.sv
// Shared helpers for the single-clock FIFO: address-width function and
// read-port latency selectors for the embedded RAM.
package fifo_sync_flags_pkg;

  localparam int RD_LAT_COMB = 0;
  localparam int RD_LAT_REG  = 1;

  function automatic int log2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM: synchronous write port and a read port that is either
// combinational or registered (write-first on an address collision).
module fifo_ram_sdp
  import fifo_sync_flags_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 32,
  parameter int READ_LATENCY = RD_LAT_REG
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_wrEn,
  input  logic [log2(DEPTH)-1:0]   i_wrAddr,
  input  logic [DATA_WIDTH-1:0]    i_wrData,
  input  logic                     i_rdEn,
  input  logic [log2(DEPTH)-1:0]   i_rdAddr,
  output logic [DATA_WIDTH-1:0]    o_rdData
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  generate
    if (READ_LATENCY == RD_LAT_COMB) begin : g_combRead
      assign o_rdData = r_mem[i_rdAddr];
    end else begin : g_regRead
      // Write-first bypass lets a look-ahead read see a word written on the same edge
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          o_rdData <= '0;
        end else if (i_rdEn) begin
          o_rdData <= (i_wrEn && (i_wrAddr == i_rdAddr)) ? i_wrData : r_mem[i_rdAddr];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, programmable threshold flags,
// optional first-word-fall-through read and sticky overflow/underflow flags.
module fifo_sync_flags
  import fifo_sync_flags_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 32,
  parameter int FWFT         = 0,
  parameter int AFULL_LEVEL  = FIFO_DEPTH - 2,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                      rd_clk,
  input  logic                      PresetFull,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      rd_en,
  input  logic                      clr_err,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [log2(FIFO_DEPTH):0] count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = log2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  generate
    if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_badDepth
      $error("fifo_sync_flags: FIFO_DEPTH must be a power of two and at least 4");
    end
    if ((AFULL_LEVEL < 1) || (AFULL_LEVEL > FIFO_DEPTH) || (AEMPTY_LEVEL < 0)) begin : g_badLevel
      $error("fifo_sync_flags: threshold levels out of range");
    end
  endgenerate

  logic [AW-1:0]         r_wrPtr;
  logic [AW-1:0]         r_rdPtr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_almostFull;
  logic                  r_almostEmpty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_push;
  logic                  w_pop;
  logic [CW-1:0]         w_nextCount;
  logic [AW-1:0]         w_nextRdPtr;
  logic                  w_ramRdEn;
  logic [AW-1:0]         w_ramRdAddr;
  logic [DATA_WIDTH-1:0] w_ramData;

  // FWFT keeps the output register loaded with the head of the next state,
  // so it reads one address ahead whenever the FIFO will not be empty.
  always_comb begin
    w_push      = wr_en & ~r_full;
    w_pop       = rd_en & ~r_empty;
    w_nextCount = r_count + CW'(w_push) - CW'(w_pop);
    w_nextRdPtr = r_rdPtr + AW'(w_pop);
    w_ramRdEn   = w_pop;
    w_ramRdAddr = r_rdPtr;
    if (FWFT != 0) begin
      w_ramRdEn   = (w_nextCount != '0);
      w_ramRdAddr = w_nextRdPtr;
    end
  end

  always_ff @(posedge rd_clk or posedge PresetFull) begin
    if (PresetFull) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_almostFull  <= (AFULL_LEVEL == 0);
      r_almostEmpty <= 1'b1;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      r_rdPtr       <= w_nextRdPtr;
      r_count       <= w_nextCount;
      r_full        <= (w_nextCount == CW'(FIFO_DEPTH));
      r_empty       <= (w_nextCount == '0);
      r_almostFull  <= (w_nextCount >= CW'(AFULL_LEVEL));
      r_almostEmpty <= (w_nextCount <= CW'(AEMPTY_LEVEL));
      // A fresh error outranks a concurrent clear
      r_overflow    <= (r_overflow & ~clr_err) | (wr_en & r_full);
      r_underflow   <= (r_underflow & ~clr_err) | (rd_en & r_empty);
    end
  end

  fifo_ram_sdp #(
    .DATA_WIDTH   (DATA_WIDTH),
    .DEPTH        (FIFO_DEPTH),
    .READ_LATENCY (RD_LAT_REG)
  ) u_ram (
    .i_clk    (rd_clk),
    .i_reset  (PresetFull),
    .i_wrEn   (w_push),
    .i_wrAddr (r_wrPtr),
    .i_wrData (data_in),
    .i_rdEn   (w_ramRdEn),
    .i_rdAddr (w_ramRdAddr),
    .o_rdData (w_ramData)
  );

  assign data_out     = w_ramData;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almostFull;
  assign almost_empty = r_almostEmpty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags: a standard-read and an FWFT instance share stimulus
// and are compared against a queue-based reference model.
module tb_fifo_sync_flags;

  localparam int DEPTH = 32;
  localparam int AFL   = DEPTH - 2;
  localparam int AEL   = 2;

  logic       rd_clk = 1'b0;
  logic       PresetFull = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] doutS, doutF;
  logic       fullS, emptyS, afS, aeS, ovS, unS;
  logic       fullF, emptyF, afF, aeF, ovF, unF;
  logic [5:0] countS, countF;
  logic [11:0] statusS, statusF;

  logic [7:0] q[$];
  logic       mOver, mUnder;
  logic [7:0] mDoutS, mDoutF;
  int         nVec = 0;
  int         nFail = 0;

  assign statusS = {fullS, emptyS, afS, aeS, ovS, unS, countS};
  assign statusF = {fullF, emptyF, afF, aeF, ovF, unF, countF};

  always #5 rd_clk = ~rd_clk;

  fifo_sync_flags #(.FWFT(0)) dutStd (
    .rd_clk(rd_clk), .PresetFull(PresetFull), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .clr_err(clr_err), .data_out(doutS), .full(fullS), .empty(emptyS),
    .almost_full(afS), .almost_empty(aeS), .count(countS), .overflow(ovS), .underflow(unS)
  );

  fifo_sync_flags #(.FWFT(1)) dutFwft (
    .rd_clk(rd_clk), .PresetFull(PresetFull), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .clr_err(clr_err), .data_out(doutF), .full(fullF), .empty(emptyF),
    .almost_full(afF), .almost_empty(aeF), .count(countF), .overflow(ovF), .underflow(unF)
  );

  // Expected status word derived from the occupancy of the reference queue
  function automatic logic [11:0] expStatus();
    int n;
    n = q.size();
    return {(n == DEPTH), (n == 0), (n >= AFL), (n <= AEL), mOver, mUnder, 6'(n)};
  endfunction

  task automatic resetModel();
    q.delete();
    mOver  = 1'b0;
    mUnder = 1'b0;
    mDoutS = 8'h00;
    mDoutF = 8'h00;
  endtask

  // Drive one cycle of inputs, let the edge happen, then advance the model
  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit wasFull, wasEmpty;
    @(negedge rd_clk);
    wr_en = w; data_in = d; rd_en = r; clr_err = c;
    @(posedge rd_clk);
    wasFull  = (q.size() == DEPTH);
    wasEmpty = (q.size() == 0);
    mOver  = (w && wasFull)  ? 1'b1 : (c ? 1'b0 : mOver);
    mUnder = (r && wasEmpty) ? 1'b1 : (c ? 1'b0 : mUnder);
    if (r && !wasEmpty) begin
      mDoutS = q[0];
      void'(q.pop_front());
    end
    if (w && !wasFull) q.push_back(d);
    if (q.size() != 0) mDoutF = q[0];
    #1;
  endtask

  task automatic applyReset();
    @(negedge rd_clk);
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    PresetFull = 1'b1;
    resetModel();
    @(negedge rd_clk);
    PresetFull = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge rd_clk);
    PresetFull = 1'b1;
    resetModel();
    #1;
    nVec++; if (statusS !== 12'b0101_0000_0000) begin nFail++; $display("[TB] FAIL reset_status: got %b expected %b", statusS, 12'b0101_0000_0000); end
    nVec++; if (statusF !== expStatus()) begin nFail++; $display("[TB] FAIL reset_statusF: got %b expected %b", statusF, expStatus()); end
    nVec++; if (doutS !== 8'h00) begin nFail++; $display("[TB] FAIL reset_doutS: got %h expected 00", doutS); end
    nVec++; if (doutF !== 8'h00) begin nFail++; $display("[TB] FAIL reset_doutF: got %h expected 00", doutF); end
    @(negedge rd_clk);
    PresetFull = 1'b0;
  endtask

  task automatic test_fill_drain();
    applyReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      nVec++; if (statusS !== expStatus()) begin nFail++; $display("[TB] FAIL fill_status[%0d]: got %b expected %b", i, statusS, expStatus()); end
      nVec++; if (doutF !== mDoutF) begin nFail++; $display("[TB] FAIL fill_doutF[%0d]: got %h expected %h", i, doutF, mDoutF); end
    end
    nVec++; if ({fullS, afS, countS} !== {1'b1, 1'b1, 6'd32}) begin nFail++; $display("[TB] FAIL fill_full: got %b expected 11100000", {fullS, afS, countS}); end
    applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
    nVec++; if ({ovS, countS} !== {1'b1, 6'd32}) begin nFail++; $display("[TB] FAIL push33_rejected: got %b expected 1100000", {ovS, countS}); end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    nVec++; if (statusS !== expStatus()) begin nFail++; $display("[TB] FAIL clr_overflow: got %b expected %b", statusS, expStatus()); end
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      nVec++; if (doutS !== 8'(i)) begin nFail++; $display("[TB] FAIL drain_doutS[%0d]: got %h expected %h", i, doutS, 8'(i)); end
      nVec++; if (statusS !== expStatus()) begin nFail++; $display("[TB] FAIL drain_status[%0d]: got %b expected %b", i, statusS, expStatus()); end
      nVec++; if (doutF !== mDoutF) begin nFail++; $display("[TB] FAIL drain_doutF[%0d]: got %h expected %h", i, doutF, mDoutF); end
    end
    nVec++; if (emptyS !== 1'b1) begin nFail++; $display("[TB] FAIL drain_empty: got %b expected 1", emptyS); end
  endtask

  task automatic test_latency();
    applyReset();
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    nVec++; if ({emptyF, doutF} !== {1'b0, 8'hA5}) begin nFail++; $display("[TB] FAIL fwft_first_word: got %b/%h expected 0/a5", emptyF, doutF); end
    nVec++; if (doutS !== 8'h00) begin nFail++; $display("[TB] FAIL std_before_pop: got %h expected 00", doutS); end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    nVec++; if ({emptyS, doutS} !== {1'b1, 8'hA5}) begin nFail++; $display("[TB] FAIL std_read_latency: got %b/%h expected 1/a5", emptyS, doutS); end
    nVec++; if (doutF !== 8'hA5) begin nFail++; $display("[TB] FAIL fwft_hold_empty: got %h expected a5", doutF); end
  endtask

  task automatic test_back_to_back();
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0);
      nVec++; if (statusS !== expStatus() || countS !== 6'd5) begin nFail++; $display("[TB] FAIL b2b_status[%0d]: got %b expected %b", i, statusS, expStatus()); end
      nVec++; if (doutS !== mDoutS) begin nFail++; $display("[TB] FAIL b2b_doutS[%0d]: got %h expected %h", i, doutS, mDoutS); end
      nVec++; if (doutF !== mDoutF) begin nFail++; $display("[TB] FAIL b2b_doutF[%0d]: got %h expected %h", i, doutF, mDoutF); end
    end
  endtask

  task automatic test_underflow();
    applyReset();
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    nVec++; if ({unS, doutS} !== {1'b1, 8'h3C}) begin nFail++; $display("[TB] FAIL underflow_set: got %b/%h expected 1/3c", unS, doutS); end
    nVec++; if (doutF !== 8'h3C) begin nFail++; $display("[TB] FAIL underflow_doutF: got %h expected 3c", doutF); end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    nVec++; if (unS !== 1'b1) begin nFail++; $display("[TB] FAIL underflow_err_wins: got %b expected 1", unS); end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    nVec++; if (statusS !== expStatus() || unS !== 1'b0) begin nFail++; $display("[TB] FAIL underflow_clear: got %b expected %b", statusS, expStatus()); end
  endtask

  task automatic test_full_simul();
    applyReset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    nVec++; if ({fullS, ovS, countS} !== {1'b0, 1'b1, 6'd31}) begin nFail++; $display("[TB] FAIL full_simul: got %b expected 01011111", {fullS, ovS, countS}); end
    nVec++; if (doutS !== 8'h40) begin nFail++; $display("[TB] FAIL full_simul_doutS: got %h expected 40", doutS); end
    nVec++; if (doutF !== 8'h41) begin nFail++; $display("[TB] FAIL full_simul_doutF: got %h expected 41", doutF); end
  endtask

  task automatic test_async_reset();
    applyReset();
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'($urandom), (i % 4) == 3, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    nVec++; if (countS !== 6'(q.size())) begin nFail++; $display("[TB] FAIL pre_reset_count: got %0d expected %0d", countS, q.size()); end
    #2;
    PresetFull = 1'b1;
    wr_en = 1'b0;
    resetModel();
    #1;
    nVec++; if ({countS, emptyS, fullS, doutS} !== {6'd0, 1'b1, 1'b0, 8'h00}) begin nFail++; $display("[TB] FAIL async_reset: got %b expected 000000_1_0_00000000", {countS, emptyS, fullS, doutS}); end
    nVec++; if (statusF !== expStatus() || doutF !== 8'h00) begin nFail++; $display("[TB] FAIL async_resetF: got %b/%h expected %b/00", statusF, doutF, expStatus()); end
    @(negedge rd_clk);
    PresetFull = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i < 10, 8'($urandom), i >= 10, 1'b0);
      nVec++; if (statusS !== expStatus()) begin nFail++; $display("[TB] FAIL refill_status[%0d]: got %b expected %b", i, statusS, expStatus()); end
      nVec++; if ({doutS, doutF} !== {mDoutS, mDoutF}) begin nFail++; $display("[TB] FAIL refill_dout[%0d]: got %h/%h expected %h/%h", i, doutS, doutF, mDoutS, mDoutF); end
    end
  endtask

  task automatic test_random();
    logic w, r, c;
    applyReset();
    for (int i = 0; i < 400; i++) begin
      w = (i < 200) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      r = (i < 200) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      c = ($urandom_range(7) == 0);
      applyStimulus(w, 8'($urandom), r, c);
      nVec++; if (statusS !== expStatus()) begin nFail++; $display("[TB] FAIL rand_status[%0d]: got %b expected %b", i, statusS, expStatus()); end
      nVec++; if (statusF !== expStatus()) begin nFail++; $display("[TB] FAIL rand_statusF[%0d]: got %b expected %b", i, statusF, expStatus()); end
      nVec++; if ({doutS, doutF} !== {mDoutS, mDoutF}) begin nFail++; $display("[TB] FAIL rand_dout[%0d]: got %h/%h expected %h/%h", i, doutS, doutF, mDoutS, mDoutF); end
    end
  endtask

  initial begin
    resetModel();
    test_reset();
    test_fill_drain();
    test_latency();
    test_back_to_back();
    test_underflow();
    test_full_simul();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
